// File: rtl/pipeline_ctrl_n_pkg.sv
// Shared defines for the pipeline controller: exception codes, flush causes,
// control constants, the instruction address type, the FSM state type and
// the exception vector helper.
package pipeline_ctrl_n_pkg;

    localparam int INST_ADDR_W = 32;
    typedef logic [INST_ADDR_W-1:0] inst_addr_t;

    // Exception codes as produced by the commit stage
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_TR   = 5'h0d;
    localparam logic [4:0] EXC_ERET = 5'h0e;

    // Flush cause codes
    localparam logic CAUSE_EXCEPTION     = 1'b0;
    localparam logic CAUSE_FAILED_BRANCH = 1'b1;

    // Control constants
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam logic FLUSH_EN   = 1'b1;
    localparam logic NO_FLUSH   = 1'b0;
    localparam logic RST_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_PEND
    } ctrl_state_t;

    // Restart address for an exception: EPC for ERET, common vector for the
    // known codes, zero for anything unrecognised.
    function automatic inst_addr_t exc_vector(input logic [4:0] code,
                                              input inst_addr_t epc,
                                              input inst_addr_t ebase,
                                              input inst_addr_t offset);
        case (code)
            EXC_ERET:                    return epc;
            EXC_INT, EXC_ADEL, EXC_ADES,
            EXC_SYS, EXC_BP, EXC_RI,
            EXC_OV, EXC_TR:              return ebase + offset;
            default:                     return '0;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_ctrl_n_stall_mask_gen.sv
// Priority encoder from per-stage stall requests to stall/bubble masks.
// The highest requesting stage k holds stages 0..k and injects a bubble
// into stage k+1. Purely combinational.
module stall_mask_gen
    import pipeline_ctrl_n_pkg::*;
#(
    parameter int NUM_STAGES = 5
) (
    input  logic [NUM_STAGES-1:0] stallreq,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] bubble
);

    logic any_above;

    // Scan from writeback down: a stage stalls if it or any later stage asks
    always_comb begin
        // NOTE: any_above is a combinational temporary reused across loop
        // iterations, so it is assigned with blocking '=' and given a default
        // first; every output also gets a default so no latch is inferred.
        any_above = NO_STOP;
        stall     = '0;
        bubble    = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            any_above = any_above | stallreq[i];
            stall[i]  = any_above;
        end
        for (int i = 1; i < NUM_STAGES; i++) begin
            bubble[i] = stall[i-1] & ~stall[i];
        end
    end

endmodule

// File: rtl/pipeline_ctrl_n.sv
// Hazard/flush controller: stall/bubble masks, exception/ERET/mispredict
// redirect arbitration, programmable flush hold, and parking of a mispredict
// that is blocked by a memory-stage (or later) stall.
module pipeline_ctrl_n
    import pipeline_ctrl_n_pkg::*;
#(
    parameter int          NUM_STAGES = 5,
    parameter int          MEM_STAGE  = 3,
    parameter int          FLUSH_HOLD = 1,
    parameter logic [31:0] EXC_OFFSET = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stallreq,
    input  logic                  exception_flag,
    input  logic [4:0]            exception_type,
    input  logic [31:0]           cp0_epc_i,
    input  logic [31:0]           ebase_i,
    input  logic                  mispredict_valid,
    input  logic [31:0]           mispredict_pc,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] bubble,
    output logic                  flush,
    output logic                  flush_cause,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    output logic                  flush_to_ibuffer
);

    localparam int             CW         = $clog2(FLUSH_HOLD + 1);
    localparam logic [CW-1:0]  HOLD_LOAD  = CW'(FLUSH_HOLD - 1);
    localparam bit             HOLD_MULTI = (FLUSH_HOLD > 1);

    ctrl_state_t           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pend_v_q, pend_v_d;
    inst_addr_t            pend_pc_q, pend_pc_d;
    logic                  cause_q, cause_c;
    logic                  flush_c, redir_v_c;
    inst_addr_t            redir_pc_c;
    logic                  mem_block;
    logic [NUM_STAGES-1:0] stall_raw, bubble_raw;

    stall_mask_gen #(.NUM_STAGES(NUM_STAGES)) u_mask (
        .stallreq (stallreq),
        .stall    (stall_raw),
        .bubble   (bubble_raw)
    );

    assign mem_block = |stallreq[NUM_STAGES-1:MEM_STAGE];

    // Arbitrate exception > flush hold > memory stall > mispredict > masks
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_v_d   = pend_v_q;
        pend_pc_d  = pend_pc_q;
        cause_c    = cause_q;
        flush_c    = NO_FLUSH;
        redir_v_c  = 1'b0;
        redir_pc_c = '0;
        if (exception_flag) begin
            flush_c    = FLUSH_EN;
            cause_c    = CAUSE_EXCEPTION;
            redir_v_c  = 1'b1;
            redir_pc_c = exc_vector(exception_type, cp0_epc_i, ebase_i, EXC_OFFSET);
            pend_v_d   = 1'b0;
            pend_pc_d  = '0;
            state_d    = HOLD_MULTI ? ST_FLUSH : ST_RUN;
            cnt_d      = HOLD_LOAD;
        end else if (state_q == ST_FLUSH) begin
            // Wrong-path mispredicts are ignored while the hold runs out
            flush_c = FLUSH_EN;
            if (cnt_q > CW'(1)) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
        end else if (state_q == ST_PEND) begin
            if (!mem_block) begin
                flush_c    = FLUSH_EN;
                cause_c    = CAUSE_FAILED_BRANCH;
                redir_v_c  = 1'b1;
                redir_pc_c = pend_pc_q;
                pend_v_d   = 1'b0;
                pend_pc_d  = '0;
                state_d    = HOLD_MULTI ? ST_FLUSH : ST_RUN;
                cnt_d      = HOLD_LOAD;
            end
        end else if (mispredict_valid) begin
            if (mem_block) begin
                pend_v_d  = 1'b1;
                pend_pc_d = mispredict_pc;
                state_d   = ST_PEND;
            end else begin
                flush_c    = FLUSH_EN;
                cause_c    = CAUSE_FAILED_BRANCH;
                redir_v_c  = 1'b1;
                redir_pc_c = mispredict_pc;
                state_d    = HOLD_MULTI ? ST_FLUSH : ST_RUN;
                cnt_d      = HOLD_LOAD;
            end
        end
    end

    // Controller state, hold counter, parked mispredict and latched cause
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registered state uses non-blocking '<=' so every flop samples
        // the pre-edge values; the async reset returns all of it to RUN/idle.
        if (rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            pend_v_q  <= 1'b0;
            pend_pc_q <= '0;
            cause_q   <= CAUSE_EXCEPTION;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
            cause_q   <= cause_c;
        end
    end

    // Outputs are quiet during reset; masks are suppressed by any flush
    always_comb begin
        flush            = ~rst & flush_c;
        flush_cause      = flush ? cause_c : 1'b0;
        redirect_valid   = ~rst & redir_v_c;
        redirect_pc      = redirect_valid ? redir_pc_c : '0;
        stall            = (rst || flush_c) ? '0 : stall_raw;
        bubble           = (rst || flush_c) ? '0 : bubble_raw;
        flush_to_ibuffer = (rst == RST_ENABLE) | flush;
    end

endmodule

// File: tb/tb_pipeline_ctrl_n.sv
// Directed bench for pipeline_ctrl_n. dut_a runs with a 3-cycle flush hold and
// a 0x180 vector offset; dut_b uses the defaults and shares every input.
module tb_pipeline_ctrl_n;
    import pipeline_ctrl_n_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  stallreq;
    logic        exception_flag;
    logic [4:0]  exception_type;
    logic [31:0] cp0_epc_i, ebase_i, mispredict_pc;
    logic        mispredict_valid;

    logic [4:0]  a_stall, a_bubble, b_stall, b_bubble;
    logic        a_flush, a_cause, a_rv, a_fti;
    logic        b_flush, b_cause, b_rv, b_fti;
    logic [31:0] a_rpc, b_rpc;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_n #(.NUM_STAGES(5), .MEM_STAGE(3), .FLUSH_HOLD(3), .EXC_OFFSET(32'h180)) dut_a (
        .clk(clk), .rst(rst), .stallreq(stallreq),
        .exception_flag(exception_flag), .exception_type(exception_type),
        .cp0_epc_i(cp0_epc_i), .ebase_i(ebase_i),
        .mispredict_valid(mispredict_valid), .mispredict_pc(mispredict_pc),
        .stall(a_stall), .bubble(a_bubble), .flush(a_flush), .flush_cause(a_cause),
        .redirect_valid(a_rv), .redirect_pc(a_rpc), .flush_to_ibuffer(a_fti)
    );

    pipeline_ctrl_n dut_b (
        .clk(clk), .rst(rst), .stallreq(stallreq),
        .exception_flag(exception_flag), .exception_type(exception_type),
        .cp0_epc_i(cp0_epc_i), .ebase_i(ebase_i),
        .mispredict_valid(mispredict_valid), .mispredict_pc(mispredict_pc),
        .stall(b_stall), .bubble(b_bubble), .flush(b_flush), .flush_cause(b_cause),
        .redirect_valid(b_rv), .redirect_pc(b_rpc), .flush_to_ibuffer(b_fti)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle();
        stallreq         = '0;
        exception_flag   = 1'b0;
        exception_type   = '0;
        mispredict_valid = 1'b0;
        mispredict_pc    = '0;
    endtask

    // Advance to the next negedge; inputs change there, checks follow #1 later
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        cp0_epc_i = 32'h0;
        ebase_i   = 32'hBFC00200;
        stallreq  = 5'b00100;
        #1;
        check("rst_fti",   {31'b0, a_fti},   32'd1);
        check("rst_flush", {31'b0, a_flush}, 32'd0);
        check("rst_stall", {27'b0, a_stall}, 32'd0);
        check("rst_rv",    {31'b0, a_rv},    32'd0);
        next_cycle();
        rst = 1'b0;
        idle();

        // Stall masks
        next_cycle(); stallreq = 5'b00100; #1;
        check("mask_stall_k2",  {27'b0, a_stall},  32'b00111);
        check("mask_bubble_k2", {27'b0, a_bubble}, 32'b01000);
        check("mask_flush_k2",  {31'b0, a_flush},  32'd0);
        check("mask_fti_k2",    {31'b0, a_fti},    32'd0);
        next_cycle(); stallreq = 5'b00000; #1;
        check("mask_stall_none",  {27'b0, a_stall},  32'd0);
        check("mask_bubble_none", {27'b0, a_bubble}, 32'd0);
        next_cycle(); stallreq = 5'b10010; #1;
        check("mask_stall_k4",  {27'b0, a_stall},  32'b11111);
        check("mask_bubble_k4", {27'b0, a_bubble}, 32'b00000);
        next_cycle(); stallreq = 5'b00001; #1;
        check("mask_stall_k0",  {27'b0, a_stall},  32'b00001);
        check("mask_bubble_k0", {27'b0, a_bubble}, 32'b00010);

        // SYS exception overrides a full stall request
        next_cycle(); stallreq = 5'b11111; exception_flag = 1'b1; exception_type = EXC_SYS; #1;
        check("sys_flush",  {31'b0, a_flush}, 32'd1);
        check("sys_rv",     {31'b0, a_rv},    32'd1);
        check("sys_rpc",    a_rpc,            32'hBFC00380);
        check("sys_cause",  {31'b0, a_cause}, {31'b0, CAUSE_EXCEPTION});
        check("sys_stall",  {27'b0, a_stall}, 32'd0);
        check("sys_bubble", {27'b0, a_bubble}, 32'd0);
        check("sys_fti",    {31'b0, a_fti},   32'd1);
        check("sys_b_rpc",  b_rpc,            32'hBFC00200);
        next_cycle(); idle(); #1;
        check("sys_hold1_flush", {31'b0, a_flush}, 32'd1);
        check("sys_hold1_rv",    {31'b0, a_rv},    32'd0);
        check("sys_b_done",      {31'b0, b_flush}, 32'd0);
        next_cycle(); #1;
        check("sys_hold2_flush", {31'b0, a_flush}, 32'd1);
        next_cycle(); #1;
        check("sys_end_flush", {31'b0, a_flush}, 32'd0);

        // Mispredict parked behind a memory-stage stall for 4 cycles
        next_cycle(); stallreq = 5'b01000; mispredict_valid = 1'b1; mispredict_pc = 32'h80001000; #1;
        check("pend_c1_flush",  {31'b0, a_flush},  32'd0);
        check("pend_c1_stall",  {27'b0, a_stall},  32'b01111);
        check("pend_c1_bubble", {27'b0, a_bubble}, 32'b10000);
        next_cycle(); mispredict_pc = 32'hDEAD0000; #1;
        check("pend_c2_flush", {31'b0, a_flush}, 32'd0);
        next_cycle(); mispredict_valid = 1'b0; #1;
        check("pend_c3_flush", {31'b0, a_flush}, 32'd0);
        next_cycle(); #1;
        check("pend_c4_flush", {31'b0, a_flush}, 32'd0);
        next_cycle(); stallreq = 5'b00000; #1;
        check("pend_c5_flush", {31'b0, a_flush}, 32'd1);
        check("pend_c5_cause", {31'b0, a_cause}, {31'b0, CAUSE_FAILED_BRANCH});
        check("pend_c5_rv",    {31'b0, a_rv},    32'd1);
        check("pend_c5_rpc",   a_rpc,            32'h80001000);
        check("pend_c5_b_rpc", b_rpc,            32'h80001000);
        next_cycle(); #1;
        check("pend_hold_cause", {31'b0, a_cause}, {31'b0, CAUSE_FAILED_BRANCH});
        next_cycle(); #1;
        next_cycle(); #1;
        check("pend_end_flush", {31'b0, a_flush}, 32'd0);

        // ERET while a mispredict is parked: pending pc is discarded
        next_cycle(); stallreq = 5'b10000; mispredict_valid = 1'b1; mispredict_pc = 32'h80002000; #1;
        check("eret_pend_flush", {31'b0, a_flush}, 32'd0);
        next_cycle(); mispredict_valid = 1'b0; exception_flag = 1'b1; exception_type = EXC_ERET;
        cp0_epc_i = 32'h80000040; #1;
        check("eret_pend_rpc",   a_rpc,            32'h80000040);
        check("eret_pend_cause", {31'b0, a_cause}, {31'b0, CAUSE_EXCEPTION});
        next_cycle(); idle(); #1;
        next_cycle(); #1;
        next_cycle(); #1;
        check("eret_pend_gone_flush", {31'b0, a_flush}, 32'd0);
        check("eret_pend_gone_b",     {31'b0, b_flush}, 32'd0);
        next_cycle(); #1;
        check("eret_pend_gone_rv", {31'b0, a_rv}, 32'd0);

        // ERET with 3-cycle hold; mispredict in cycle 2 ignored
        next_cycle(); exception_flag = 1'b1; exception_type = EXC_ERET; cp0_epc_i = 32'h80000100; #1;
        check("hold_c1_flush", {31'b0, a_flush}, 32'd1);
        check("hold_c1_rv",    {31'b0, a_rv},    32'd1);
        check("hold_c1_rpc",   a_rpc,            32'h80000100);
        next_cycle(); idle(); mispredict_valid = 1'b1; mispredict_pc = 32'h80003000; #1;
        check("hold_c2_flush", {31'b0, a_flush}, 32'd1);
        check("hold_c2_rv",    {31'b0, a_rv},    32'd0);
        next_cycle(); mispredict_valid = 1'b0; #1;
        check("hold_c3_flush", {31'b0, a_flush}, 32'd1);
        check("hold_c3_rv",    {31'b0, a_rv},    32'd0);
        next_cycle(); #1;
        check("hold_c4_flush", {31'b0, a_flush}, 32'd0);
        check("hold_c4_rv",    {31'b0, a_rv},    32'd0);

        // Exception and mispredict together: exception wins; unknown code gives 0
        next_cycle(); exception_flag = 1'b1; exception_type = 5'h1f;
        mispredict_valid = 1'b1; mispredict_pc = 32'h80004000; #1;
        check("unk_flush", {31'b0, a_flush}, 32'd1);
        check("unk_cause", {31'b0, a_cause}, {31'b0, CAUSE_EXCEPTION});
        check("unk_rpc",   a_rpc,            32'h0);
        next_cycle(); idle(); #1;
        next_cycle(); #1;
        next_cycle(); #1;
        check("unk_end_flush", {31'b0, a_flush}, 32'd0);

        // Async reset in the middle of a flush hold
        next_cycle(); exception_flag = 1'b1; exception_type = EXC_ERET; cp0_epc_i = 32'h80000200; #1;
        check("rstmid_c1_flush", {31'b0, a_flush}, 32'd1);
        next_cycle(); idle(); #1;
        check("rstmid_c2_flush", {31'b0, a_flush}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstmid_flush", {31'b0, a_flush}, 32'd0);
        check("rstmid_fti",   {31'b0, a_fti},   32'd1);
        check("rstmid_rv",    {31'b0, a_rv},    32'd0);
        next_cycle(); #1;
        check("rstmid_fti_held", {31'b0, a_fti}, 32'd1);
        rst = 1'b0;
        #1;
        check("rstrel_fti",   {31'b0, a_fti},   32'd0);
        check("rstrel_flush", {31'b0, a_flush}, 32'd0);
        next_cycle(); #1;
        check("rstrel_run_flush", {31'b0, a_flush}, 32'd0);
        check("rstrel_run_fti",   {31'b0, a_fti},   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
